// File: rtl/ball_engine_if.sv
// Signal bundle between the pong playfield logic and the ball engine.
// The driving side (master) supplies the motion tick and the playfield and
// paddle geometry; the engine (slave) returns the registered ball box,
// score pulses, current speed and the playing flag.
//
// Timing contract: there is no valid/ready pair on this bus. 'move' is a
// strobe: each cycle it is high counts as exactly one motion tick, and
// geometry inputs are sampled on every rising clock edge.
interface ball_engine_if #(
  parameter int W       = 10,
  parameter int SPEED_W = 3
);
  logic               move;
  logic [W-1:0]       borderHmin;
  logic [W-1:0]       borderHmax;
  logic [W-1:0]       borderVmin;
  logic [W-1:0]       borderVmax;
  logic [W-1:0]       LHmin;
  logic [W-1:0]       LHmax;
  logic [W-1:0]       LVmin;
  logic [W-1:0]       LVmax;
  logic [W-1:0]       RHmin;
  logic [W-1:0]       RHmax;
  logic [W-1:0]       RVmin;
  logic [W-1:0]       RVmax;
  logic [W-1:0]       BHmin;
  logic [W-1:0]       BHmax;
  logic [W-1:0]       BVmin;
  logic [W-1:0]       BVmax;
  logic               scoreL;
  logic               scoreR;
  logic [SPEED_W-1:0] speed;
  logic               playing;

  modport master (
    output move, borderHmin, borderHmax, borderVmin, borderVmax,
           LHmin, LHmax, LVmin, LVmax, RHmin, RHmax, RVmin, RVmax,
    input  BHmin, BHmax, BVmin, BVmax, scoreL, scoreR, speed, playing
  );

  modport slave (
    input  move, borderHmin, borderHmax, borderVmin, borderVmax,
           LHmin, LHmax, LVmin, LVmax, RHmin, RHmax, RVmin, RVmax,
    output BHmin, BHmax, BVmin, BVmax, scoreL, scoreR, speed, playing
  );
endinterface

// File: rtl/ball_engine.sv
// Pong ball engine: serve hold, motion with wall bounce, paddle hits with
// speed-up every few hits, and one-cycle score reporting when a paddle misses.
module ball_engine #(
  parameter int W                = 10,
  parameter int BALL_SIZE        = 10,
  parameter int START_H          = 395,
  parameter int START_V          = 295,
  parameter int SPEED_MAX        = 4,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int SERVE_DELAY      = 60
) (
  input  logic           CLK_100MHz,
  input  logic           Reset,
  ball_engine_if.slave   bus,
  output logic [1:0]     dbg_state
);

  localparam int SPEED_W = $clog2(SPEED_MAX + 1);
  localparam int HIT_W   = $clog2(HITS_PER_SPEEDUP + 1);
  localparam int SRV_W   = $clog2(SERVE_DELAY + 1);

  localparam logic [W-1:0]       START_H_W = W'(START_H);
  localparam logic [W-1:0]       START_V_W = W'(START_V);
  localparam logic [W-1:0]       BALL_W    = W'(BALL_SIZE);
  localparam logic [SPEED_W-1:0] SPEED_ONE = SPEED_W'(1);
  localparam logic [SPEED_W-1:0] SPEED_TOP = SPEED_W'(SPEED_MAX);
  localparam logic [HIT_W-1:0]   HIT_LAST  = HIT_W'(HITS_PER_SPEEDUP - 1);
  localparam logic [SRV_W-1:0]   SRV_LAST  = SRV_W'(SERVE_DELAY - 1);

  typedef enum logic [1:0] {
    ST_SERVE  = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SCORED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       bh_min_q, bh_min_d;
  logic [W-1:0]       bh_max_q, bh_max_d;
  logic [W-1:0]       bv_min_q, bv_min_d;
  logic [W-1:0]       bv_max_q, bv_max_d;
  logic               dir_h_q, dir_h_d;
  logic               dir_v_q, dir_v_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [HIT_W-1:0]   hits_q, hits_d;
  logic [SRV_W-1:0]   serve_cnt_q, serve_cnt_d;
  logic               exit_left_q, exit_left_d;

  // Edge tests are done one bit wider than the coordinates so that
  // "edge minus speed" never underflows and "edge plus speed" never wraps;
  // subtraction is rewritten as addition on the other side of the compare.
  logic [W:0] spd_x;
  logic       up_bounce, dn_bounce;
  logic       v_overlap_l, v_overlap_r;
  logic       hit_l, hit_r, miss_l, miss_r;

  assign spd_x       = (W+1)'(speed_q);
  assign up_bounce   = ({1'b0, bv_min_q} <= ({1'b0, bus.borderVmin} + spd_x));
  assign dn_bounce   = (({1'b0, bv_max_q} + spd_x) >= {1'b0, bus.borderVmax});
  assign v_overlap_l = (bv_max_q >= bus.LVmin) && (bv_min_q <= bus.LVmax);
  assign v_overlap_r = (bv_max_q >= bus.RVmin) && (bv_min_q <= bus.RVmax);
  assign hit_l  = !dir_h_q && ({1'b0, bh_min_q} <= ({1'b0, bus.LHmax} + spd_x))
                  && (bh_min_q > bus.LHmax) && v_overlap_l;
  assign hit_r  = dir_h_q && (({1'b0, bh_max_q} + spd_x) >= {1'b0, bus.RHmin})
                  && (bh_max_q < bus.RHmin) && v_overlap_r;
  assign miss_l = !dir_h_q && !hit_l
                  && ({1'b0, bh_min_q} <= ({1'b0, bus.borderHmin} + spd_x));
  assign miss_r = dir_h_q && !hit_r
                  && (({1'b0, bh_max_q} + spd_x) >= {1'b0, bus.borderHmax});

  // Paddle outer edges do not take part in collision; fold them away.
  logic unused_paddle_edges;
  assign unused_paddle_edges = ^{bus.LHmin, bus.RHmax};

  // Next-state, motion, collision and scoring decisions.
  always_comb begin
    state_d     = state_q;
    bh_min_d    = bh_min_q;
    bh_max_d    = bh_max_q;
    bv_min_d    = bv_min_q;
    bv_max_d    = bv_max_q;
    dir_h_d     = dir_h_q;
    dir_v_d     = dir_v_q;
    speed_d     = speed_q;
    hits_d      = hits_q;
    serve_cnt_d = serve_cnt_q;
    exit_left_d = exit_left_q;

    case (state_q)
      ST_SERVE: begin
        bh_min_d = START_H_W;
        bh_max_d = START_H_W + BALL_W;
        bv_min_d = START_V_W;
        bv_max_d = START_V_W + BALL_W;
        if (bus.move) begin
          if (serve_cnt_q == SRV_LAST) begin
            serve_cnt_d = '0;
            state_d     = ST_PLAY;
          end else begin
            serve_cnt_d = serve_cnt_q + SRV_W'(1);
          end
        end
      end

      ST_PLAY: begin
        if (bus.move) begin
          if (miss_l || miss_r) begin
            // Ball freezes where it is; the score is reported next cycle.
            exit_left_d = miss_l;
            state_d     = ST_SCORED;
          end else begin
            if (!dir_v_q) begin
              if (up_bounce) begin
                bv_min_d = bus.borderVmin;
                bv_max_d = bus.borderVmin + BALL_W;
                dir_v_d  = 1'b1;
              end else begin
                bv_min_d = bv_min_q - W'(speed_q);
                bv_max_d = bv_max_q - W'(speed_q);
              end
            end else begin
              if (dn_bounce) begin
                bv_max_d = bus.borderVmax;
                bv_min_d = bus.borderVmax - BALL_W;
                dir_v_d  = 1'b0;
              end else begin
                bv_min_d = bv_min_q + W'(speed_q);
                bv_max_d = bv_max_q + W'(speed_q);
              end
            end

            if (hit_l) begin
              bh_min_d = bus.LHmax;
              bh_max_d = bus.LHmax + BALL_W;
              dir_h_d  = 1'b1;
            end else if (hit_r) begin
              bh_max_d = bus.RHmin;
              bh_min_d = bus.RHmin - BALL_W;
              dir_h_d  = 1'b0;
            end else if (!dir_h_q) begin
              bh_min_d = bh_min_q - W'(speed_q);
              bh_max_d = bh_max_q - W'(speed_q);
            end else begin
              bh_min_d = bh_min_q + W'(speed_q);
              bh_max_d = bh_max_q + W'(speed_q);
            end

            if (hit_l || hit_r) begin
              if (hits_q == HIT_LAST) begin
                hits_d = '0;
                if (speed_q != SPEED_TOP) begin
                  speed_d = speed_q + SPEED_ONE;
                end
              end else begin
                hits_d = hits_q + HIT_W'(1);
              end
            end
          end
        end
      end

      ST_SCORED: begin
        bh_min_d    = START_H_W;
        bh_max_d    = START_H_W + BALL_W;
        bv_min_d    = START_V_W;
        bv_max_d    = START_V_W + BALL_W;
        speed_d     = SPEED_ONE;
        hits_d      = '0;
        serve_cnt_d = '0;
        // Serve toward the side that just conceded.
        dir_h_d     = !exit_left_q;
        state_d     = ST_SERVE;
      end

      default: begin
        state_d = ST_SERVE;
      end
    endcase
  end

  // State register with synchronous reset overriding everything.
  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      state_q     <= ST_SERVE;
      bh_min_q    <= START_H_W;
      bh_max_q    <= START_H_W + BALL_W;
      bv_min_q    <= START_V_W;
      bv_max_q    <= START_V_W + BALL_W;
      dir_h_q     <= 1'b0;
      dir_v_q     <= 1'b0;
      speed_q     <= SPEED_ONE;
      hits_q      <= '0;
      serve_cnt_q <= '0;
      exit_left_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bh_min_q    <= bh_min_d;
      bh_max_q    <= bh_max_d;
      bv_min_q    <= bv_min_d;
      bv_max_q    <= bv_max_d;
      dir_h_q     <= dir_h_d;
      dir_v_q     <= dir_v_d;
      speed_q     <= speed_d;
      hits_q      <= hits_d;
      serve_cnt_q <= serve_cnt_d;
      exit_left_q <= exit_left_d;
    end
  end

  assign bus.BHmin   = bh_min_q;
  assign bus.BHmax   = bh_max_q;
  assign bus.BVmin   = bv_min_q;
  assign bus.BVmax   = bv_max_q;
  assign bus.speed   = speed_q;
  assign bus.playing = (state_q == ST_PLAY);
  // Score pulses live only in SCORED and are suppressed if reset aborts it.
  assign bus.scoreR  = (state_q == ST_SCORED) && exit_left_q && !Reset;
  assign bus.scoreL  = (state_q == ST_SCORED) && !exit_left_q && !Reset;
  assign dbg_state   = state_q;

endmodule
